maze_qos_req_buffer: RTL
========================

Name: maze_qos_req_buffer

Overview:
Requester-side companion to the MAZE QoS arbiter. It is an input-port FIFO that stores flits with their QoS bit and presents the head entry to the arbiter as one req/qos lane. It pops on gnt. Because the arbiter uses fixed priority, the block ages a waiting head entry and promotes it to high QoS when the age limit is reached, which prevents starvation. One instance sits per arbiter input lane, and its req/qos/gnt bits connect to a single bit of the arbiter vectors.

Parameters:
DATA_W, 32, flit payload width
DEPTH, 4, FIFO entries; power of 2, >=2
AGE_MAX, 15, cycles of unserved head request before QoS promotion; >=1
AGE_W, 4, age counter width; must satisfy 2^AGE_W-1 >= AGE_MAX

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream flit valid
in_ready  out  1  buffer can accept; = !full
in_data  in  DATA_W  upstream flit payload
in_qos  in  1  upstream flit QoS (1 = high)
req  out  1  request to arbiter lane; = !empty
qos  out  1  QoS to arbiter lane
out_data  out  DATA_W  head payload; valid while req=1
gnt  in  1  grant from arbiter lane (combinational from req/qos)
count  out  $clog2(DEPTH)+1  current occupancy
promoted  out  1  head is QoS-promoted by aging
gnt_err  out  1  sticky: gnt seen while req=0

Behaviour:
- Reset (rst_n=0, async): wr/rd pointers=0, count=0, age=0, gnt_err=0. Outputs are therefore in_ready=1, req=0, qos=0, promoted=0, out_data=0. Storage contents are not reset, but out_data is forced to 0 when empty.
- Push: in_valid & in_ready at a clk edge writes {in_qos,in_data} at wr_ptr. wr_ptr wraps modulo DEPTH.
- Pop: gnt & req at a clk edge advances rd_ptr (wraps modulo DEPTH).
- count is +1 on push only, -1 on pop only, and unchanged on push+pop.
- Latency: a flit pushed into an empty buffer appears on req/out_data the next cycle. There is no combinational in→out path.
- Full (count=DEPTH): in_ready=0, and the push is ignored even if a pop occurs the same cycle. in_ready depends on registered count only.
- Empty (count=0): req=0, qos=0, out_data=0. Push and pop cannot coincide because req=0.
- qos = req & (head_qos | promoted).
- Age counter (AGE_W bits) runs from a 2-state machine:
  - IDLE: entered when empty or after a pop; age=0.
  - WAIT: entered when req=1 and the head is not popped this cycle. age increments each cycle, saturating at AGE_MAX.
  - promoted = (age==AGE_MAX) & req.
  - On pop, age clears to 0 regardless of whether the next head is present. The new head starts aging from 0 on the following cycle.
  - A head with head_qos=1 still ages, which has no visible effect on qos.
- gnt while req=0: the pointers do not move, and gnt_err sets and holds until reset.
- Mid-operation reset: all state clears immediately. In-flight flits are discarded and req drops asynchronously.

Test Plan:
- Reset, then push D=0xA5 with in_qos=0 and hold gnt=0 -> req=1 on cycle+1, qos=0; promoted=1 and qos=1 after exactly 15 more cycles. Then gnt=1 -> count=0, req=0, age back to 0.
- Push 4 flits (0x1..0x4) with gnt=0 -> count=4, in_ready=0. A 5th push with in_valid=1 is dropped. Grant 4 times -> out_data sequence 1,2,3,4 in order, then empty.
- Steady stream with push+pop every cycle at count=2 for 20 cycles -> count stays 2, in-order delivery, and pointers wrap at least 4 times.
- Head in_qos=1 -> qos=1 the first cycle req is asserted and promoted=0. Next head in_qos=0 after pop -> qos=0 and age restarts from 0.
- gnt=1 pulse while empty -> gnt_err=1 sticky, count=0, pointers unchanged. Assert rst_n=0 -> gnt_err=0.
- Full buffer with rst_n pulled low mid-cycle -> req=0, in_ready=1, count=0 asynchronously before the next clk edge.

Source files
------------

// File: rtl/maze_qos_req_buffer.sv
// Input-port FIFO for one MAZE QoS arbiter lane: presents the head flit as req/qos,
// pops on gnt, and ages an unserved head so it is promoted to high QoS.
module maze_qos_req_buffer #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int AGE_MAX = 15,
   parameter int AGE_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_qos,
   output logic                     req,
   output logic                     qos,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     gnt,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     promoted,
   output logic                     gnt_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

   typedef struct packed {
      logic              qos;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef enum logic {S_IDLE, S_WAIT} age_state_e;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [AGE_W-1:0]  age_q, age_d;
   age_state_e        state_q, state_d;
   logic              push, pop;
   entry_t            head;

   // in_ready comes from registered count only, so a pop cannot make room for a same-cycle push.
   assign in_ready = (count != CNT_W'(DEPTH));
   assign req      = (count != '0);
   assign push     = in_valid & in_ready;
   assign pop      = gnt & req;
   assign head     = mem[rd_ptr];
   assign out_data = req ? head.data : '0;
   assign promoted = req & (state_q == S_WAIT) & (age_q == AGE_LIM);
   assign qos      = req & (head.qos | promoted);

   // NOTE: storage has no reset; out_data is masked by req, so stale contents never leak out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= entry_t'{qos: in_qos, data: in_data};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         gnt_err <= 1'b0;
         age_q   <= '0;
         state_q <= S_IDLE;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (gnt && !req) gnt_err <= 1'b1;
         age_q   <= age_d;
         state_q <= state_d;
      end
   end

   // NOTE: defaults first in combinational logic so no path leaves a signal unassigned (no latch).
   always_comb begin
      state_d = S_IDLE;
      age_d   = '0;
      if (req && !pop) begin
         state_d = S_WAIT;
         age_d   = (age_q == AGE_LIM) ? age_q : age_q + AGE_W'(1);
      end
   end

endmodule
